// File: rtl/trigger_timer.sv
// Measures the latency from the start of an en window to the first trig pulse,
// reports it through a valid/ready result port and tracks the largest hit latency.
module trigger_timer #(
  parameter int CNT_W   = 24,
  parameter int ID_W    = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             trig,
  input  logic [ID_W-1:0]  attempt_id,
  input  logic             clear_max,
  output logic [CNT_W-1:0] result,
  output logic [ID_W-1:0]  result_id,
  output logic [1:0]       result_status,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] max_time,
  output logic [ID_W-1:0]  max_id,
  output logic             max_valid,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  if (TIMEOUT < 1 || longint'(TIMEOUT) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_timeout
    $error("trigger_timer: TIMEOUT out of range 1 .. 2**CNT_W-1");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    HOLD     = 2'd2,
    WAIT_LOW = 2'd3
  } state_e;

  localparam logic [1:0] ST_HIT     = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

  // Result handshake: result_valid rises on the first HOLD cycle; the consumer
  // takes the result on any edge where result_valid and result_ready are both
  // high. Result fields never change while result_valid is high.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic [ID_W-1:0]  result_id_q, result_id_d;
  logic [1:0]       result_status_q, result_status_d;
  logic             result_valid_q, result_valid_d;
  logic [CNT_W-1:0] max_time_q, max_time_d;
  logic [ID_W-1:0]  max_id_q, max_id_d;
  logic             max_valid_q, max_valid_d;
  logic             busy_q, busy_d;
  logic             hit;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    result_d        = result_q;
    result_id_d     = result_id_q;
    result_status_d = result_status_q;
    result_valid_d  = result_valid_q;
    hit             = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          cnt_d       = '0;
          result_id_d = attempt_id;
          state_d     = MEASURE;
        end
      end
      MEASURE: begin
        if (trig) begin
          result_d        = cnt_q;
          result_status_d = ST_HIT;
          result_valid_d  = 1'b1;
          hit             = 1'b1;
          state_d         = HOLD;
        end else if (!en) begin
          result_d        = cnt_q;
          result_status_d = ST_ABORT;
          result_valid_d  = 1'b1;
          state_d         = HOLD;
        end else if (cnt_q == TIMEOUT_M1) begin
          result_d        = TIMEOUT_C;
          result_status_d = ST_TIMEOUT;
          result_valid_d  = 1'b1;
          state_d         = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = en ? WAIT_LOW : IDLE;
        end
      end
      WAIT_LOW: begin
        if (!en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strict > keeps the earliest tag on ties; clear_max overrides a same-cycle hit.
    max_time_d  = max_time_q;
    max_id_d    = max_id_q;
    max_valid_d = max_valid_q;
    if (clear_max) begin
      max_time_d  = '0;
      max_id_d    = '0;
      max_valid_d = 1'b0;
    end else if (hit && (!max_valid_q || cnt_q > max_time_q)) begin
      max_time_d  = cnt_q;
      max_id_d    = result_id_q;
      max_valid_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      result_q        <= '0;
      result_id_q     <= '0;
      result_status_q <= 2'b00;
      result_valid_q  <= 1'b0;
      max_time_q      <= '0;
      max_id_q        <= '0;
      max_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      result_q        <= result_d;
      result_id_q     <= result_id_d;
      result_status_q <= result_status_d;
      result_valid_q  <= result_valid_d;
      max_time_q      <= max_time_d;
      max_id_q        <= max_id_d;
      max_valid_q     <= max_valid_d;
      busy_q          <= busy_d;
    end
  end

  assign result        = result_q;
  assign result_id     = result_id_q;
  assign result_status = result_status_q;
  assign result_valid  = result_valid_q;
  assign max_time      = max_time_q;
  assign max_id        = max_id_q;
  assign max_valid     = max_valid_q;
  assign busy          = busy_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_trigger_timer.sv
// Directed bench for trigger_timer: a TIMEOUT=64 instance for the main scenarios
// and a TIMEOUT=16 instance sharing the same inputs for the timeout scenario.
module tb_trigger_timer;

  localparam int CNT_W = 24;
  localparam int ID_W  = 8;

  logic             clk = 1'b0;
  logic             rst, en, trig, clear_max, result_ready;
  logic [ID_W-1:0]  attempt_id;

  logic [CNT_W-1:0] result, max_time, t_result, t_max_time;
  logic [ID_W-1:0]  result_id, max_id, t_result_id, t_max_id;
  logic [1:0]       result_status, state_dbg, t_result_status, t_state_dbg;
  logic             result_valid, max_valid, busy;
  logic             t_result_valid, t_max_valid, t_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  trigger_timer #(.CNT_W(CNT_W), .ID_W(ID_W), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .en(en), .trig(trig), .attempt_id(attempt_id),
    .clear_max(clear_max), .result(result), .result_id(result_id),
    .result_status(result_status), .result_valid(result_valid),
    .result_ready(result_ready), .max_time(max_time), .max_id(max_id),
    .max_valid(max_valid), .busy(busy), .state_dbg(state_dbg)
  );

  trigger_timer #(.CNT_W(CNT_W), .ID_W(ID_W), .TIMEOUT(16)) dut_t (
    .clk(clk), .rst(rst), .en(en), .trig(trig), .attempt_id(attempt_id),
    .clear_max(clear_max), .result(t_result), .result_id(t_result_id),
    .result_status(t_result_status), .result_valid(t_result_valid),
    .result_ready(result_ready), .max_time(t_max_time), .max_id(t_max_id),
    .max_valid(t_max_valid), .busy(t_busy), .state_dbg(t_state_dbg)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Opens a window, lets the counter reach lat, then fires trig on the next edge.
  task automatic run_hit(input logic [ID_W-1:0] id, input int lat, input logic clr);
    en = 1'b1;
    attempt_id = id;
    step(1);
    step(lat);
    trig = 1'b1;
    clear_max = clr;
    step(1);
    trig = 1'b0;
    clear_max = 1'b0;
  endtask

  task automatic accept();
    en = 1'b0;
    result_ready = 1'b1;
    step(1);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; trig = 1'b0; clear_max = 1'b0;
    result_ready = 1'b0; attempt_id = '0;
    step(2);
    tests_run++;
    if ({result, result_id, result_status, result_valid} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_result: got %h expected 0", {result, result_id, result_status, result_valid});
    end
    tests_run++;
    if ({max_time, max_id, max_valid, busy, state_dbg} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_max_busy: got %h expected 0", {max_time, max_id, max_valid, busy, state_dbg});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_hit();
    run_hit(8'd5, 7, 1'b0);
    tests_run++;
    if ({result, result_status, result_id, result_valid} !== {24'd7, 2'b00, 8'd5, 1'b1}) begin
      tests_failed++;
      $display("FAIL hit_result: got %h expected %h", {result, result_status, result_id, result_valid},
               {24'd7, 2'b00, 8'd5, 1'b1});
    end
    tests_run++;
    if ({max_time, max_id, max_valid} !== {24'd7, 8'd5, 1'b1}) begin
      tests_failed++;
      $display("FAIL hit_max: got %h expected %h", {max_time, max_id, max_valid}, {24'd7, 8'd5, 1'b1});
    end
    tests_run++;
    if ({busy, state_dbg} !== 3'b110) begin
      tests_failed++;
      $display("FAIL hit_busy_hold: got %b expected 110", {busy, state_dbg});
    end
    accept();
    tests_run++;
    if ({result_valid, busy, state_dbg} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL hit_accept: got %b expected 0000", {result_valid, busy, state_dbg});
    end
  endtask

  task automatic test_timeout();
    en = 1'b1; attempt_id = 8'd9;
    step(1);
    step(15);
    tests_run++;
    if ({t_result_valid, t_busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL timeout_early: got %b expected 01", {t_result_valid, t_busy});
    end
    step(1);
    tests_run++;
    if ({t_result, t_result_status, t_result_id, t_result_valid} !== {24'd16, 2'b01, 8'd9, 1'b1}) begin
      tests_failed++;
      $display("FAIL timeout_result: got %h expected %h",
               {t_result, t_result_status, t_result_id, t_result_valid}, {24'd16, 2'b01, 8'd9, 1'b1});
    end
    tests_run++;
    if ({t_max_time, t_max_id, t_max_valid} !== {24'd7, 8'd5, 1'b1}) begin
      tests_failed++;
      $display("FAIL timeout_max_kept: got %h expected %h", {t_max_time, t_max_id, t_max_valid},
               {24'd7, 8'd5, 1'b1});
    end
    result_ready = 1'b1;
    step(1);
    result_ready = 1'b0;
    tests_run++;
    if ({t_result_valid, t_busy, t_state_dbg} !== 4'b0111) begin
      tests_failed++;
      $display("FAIL timeout_wait_low: got %b expected 0111", {t_result_valid, t_busy, t_state_dbg});
    end
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    step(1);
    tests_run++;
    if ({t_result_valid, t_state_dbg} !== 3'b011) begin
      tests_failed++;
      $display("FAIL timeout_trig_ignored: got %b expected 011", {t_result_valid, t_state_dbg});
    end
    en = 1'b0;
    step(1);
    tests_run++;
    if ({t_busy, t_state_dbg} !== 3'b000) begin
      tests_failed++;
      $display("FAIL timeout_en_low_idle: got %b expected 000", {t_busy, t_state_dbg});
    end
    en = 1'b1;
    step(1);
    tests_run++;
    if ({t_busy, t_state_dbg} !== 3'b101) begin
      tests_failed++;
      $display("FAIL timeout_rearm: got %b expected 101", {t_busy, t_state_dbg});
    end
    en = 1'b0; rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_abort_hold();
    en = 1'b1; attempt_id = 8'd3;
    step(1);
    step(3);
    en = 1'b0;
    step(1);
    tests_run++;
    if ({result, result_status, result_id, result_valid} !== {24'd3, 2'b10, 8'd3, 1'b1}) begin
      tests_failed++;
      $display("FAIL abort_result: got %h expected %h", {result, result_status, result_id, result_valid},
               {24'd3, 2'b10, 8'd3, 1'b1});
    end
    for (int i = 0; i < 10; i++) begin
      en = (i % 2 == 1);
      step(1);
      tests_run++;
      if ({result, result_status, result_id, result_valid, state_dbg} !== {24'd3, 2'b10, 8'd3, 1'b1, 2'd2}) begin
        tests_failed++;
        $display("FAIL abort_hold_%0d: got %h expected %h", i,
                 {result, result_status, result_id, result_valid, state_dbg}, {24'd3, 2'b10, 8'd3, 1'b1, 2'd2});
      end
    end
    tests_run++;
    if (max_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_max: got %b expected 0", max_valid);
    end
    accept();
    tests_run++;
    if ({result_valid, busy, state_dbg} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL abort_accept: got %b expected 0000", {result_valid, busy, state_dbg});
    end
  endtask

  task automatic test_max_ties();
    int lats[4]  = '{9, 12, 12, 4};
    int ids[4]   = '{1, 2, 3, 4};
    int exp_t[4] = '{9, 12, 12, 12};
    int exp_i[4] = '{1, 2, 2, 2};
    for (int i = 0; i < 4; i++) begin
      run_hit(ID_W'(ids[i]), lats[i], 1'b0);
      tests_run++;
      if ({result, result_status, result_valid} !== {CNT_W'(lats[i]), 2'b00, 1'b1}) begin
        tests_failed++;
        $display("FAIL max_hit_%0d: got %h expected %h", i, {result, result_status, result_valid},
                 {CNT_W'(lats[i]), 2'b00, 1'b1});
      end
      tests_run++;
      if ({max_time, max_id, max_valid} !== {CNT_W'(exp_t[i]), ID_W'(exp_i[i]), 1'b1}) begin
        tests_failed++;
        $display("FAIL max_track_%0d: got %h expected %h", i, {max_time, max_id, max_valid},
                 {CNT_W'(exp_t[i]), ID_W'(exp_i[i]), 1'b1});
      end
      accept();
    end
  endtask

  task automatic test_clear_max();
    run_hit(8'd7, 20, 1'b1);
    tests_run++;
    if ({result, result_status, result_id, result_valid} !== {24'd20, 2'b00, 8'd7, 1'b1}) begin
      tests_failed++;
      $display("FAIL clear_hit_result: got %h expected %h", {result, result_status, result_id, result_valid},
               {24'd20, 2'b00, 8'd7, 1'b1});
    end
    tests_run++;
    if ({max_time, max_id, max_valid} !== 33'd0) begin
      tests_failed++;
      $display("FAIL clear_max_wins: got %h expected 0", {max_time, max_id, max_valid});
    end
    accept();
    run_hit(8'd8, 5, 1'b0);
    tests_run++;
    if ({max_time, max_id, max_valid} !== {24'd5, 8'd8, 1'b1}) begin
      tests_failed++;
      $display("FAIL clear_then_hit: got %h expected %h", {max_time, max_id, max_valid}, {24'd5, 8'd8, 1'b1});
    end
    accept();
  endtask

  task automatic test_rst_mid();
    en = 1'b1; attempt_id = 8'd6;
    step(1);
    step(4);
    rst = 1'b1; en = 1'b0;
    step(1);
    tests_run++;
    if ({result, result_id, result_status, result_valid, max_time, max_id, max_valid, busy, state_dbg} !== 70'd0) begin
      tests_failed++;
      $display("FAIL rst_measure: got %h expected 0",
               {result, result_id, result_status, result_valid, max_time, max_id, max_valid, busy, state_dbg});
    end
    rst = 1'b0;
    step(3);
    tests_run++;
    if ({result_valid, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rst_measure_no_stale: got %b expected 00", {result_valid, busy});
    end
    run_hit(8'd8, 3, 1'b0);
    tests_run++;
    if ({result, result_valid} !== {24'd3, 1'b1}) begin
      tests_failed++;
      $display("FAIL rst_pre_hold: got %h expected %h", {result, result_valid}, {24'd3, 1'b1});
    end
    rst = 1'b1;
    step(1);
    tests_run++;
    if ({result, result_id, result_status, result_valid, max_time, max_id, max_valid, busy, state_dbg} !== 70'd0) begin
      tests_failed++;
      $display("FAIL rst_hold: got %h expected 0",
               {result, result_id, result_status, result_valid, max_time, max_id, max_valid, busy, state_dbg});
    end
    rst = 1'b0;
    step(1);
    tests_run++;
    if ({result_valid, busy, state_dbg} !== 4'b0101) begin
      tests_failed++;
      $display("FAIL rst_en_held_starts: got %b expected 0101", {result_valid, busy, state_dbg});
    end
    step(2);
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    tests_run++;
    if ({result, result_status, result_id, result_valid} !== {24'd2, 2'b00, 8'd8, 1'b1}) begin
      tests_failed++;
      $display("FAIL rst_after_hit: got %h expected %h", {result, result_status, result_id, result_valid},
               {24'd2, 2'b00, 8'd8, 1'b1});
    end
    accept();
    tests_run++;
    if (result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_final_accept: got %b expected 0", result_valid);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_hit();
    test_timeout();
    test_abort_hold();
    test_max_ties();
    test_clear_max();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
